// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU controller and the
// DMA/loader port. One access per cycle, read data returned with a per-requester valid pulse.
module mem_arbiter #(
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DWIDTH-1:0] cpu_rdata,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [AWIDTH-1:0] dma_addr,
   input  logic [DWIDTH-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DWIDTH-1:0] dma_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StGntCpu, StGntDma} state_e;

   state_e state_q, state_d;
   logic   last_dma_q, last_dma_d;  // 1: DMA owned the most recent transfer
   logic   rd_valid_q;
   logic   rd_owner_dma_q;
   logic   grant_cpu, grant_dma;
   logic   xfer;

   // Grants are suppressed while rst is high so nothing reaches memory in a reset cycle.
   always_comb begin
      grant_cpu = (state_q == StGntCpu) && !rst;
      grant_dma = (state_q == StGntDma) && !rst;
   end

   assign cpu_gnt = grant_cpu;
   assign dma_gnt = grant_dma;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_cpu) begin
         mem_en    = cpu_req;
         mem_we    = cpu_we & cpu_req;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (grant_dma) begin
         mem_en    = dma_req;
         mem_we    = dma_we & dma_req;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   // A transfer is exactly a granted cycle with the owner still requesting.
   assign xfer = mem_en;

   // The tie-break uses the post-transfer owner so continuous contention alternates.
   always_comb begin
      last_dma_d = xfer ? grant_dma : last_dma_q;
      state_d    = StIdle;
      case ({cpu_req, dma_req})
         2'b11:   state_d = last_dma_d ? StGntCpu : StGntDma;
         2'b10:   state_d = StGntCpu;
         2'b01:   state_d = StGntDma;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         last_dma_q     <= 1'b1;
         rd_valid_q     <= 1'b0;
         rd_owner_dma_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_dma_q     <= last_dma_d;
         rd_valid_q     <= xfer && !mem_we;
         rd_owner_dma_q <= grant_dma;
      end
   end

   // Gating with rst drops a read return that would land in the reset cycle itself.
   assign cpu_rvalid = rd_valid_q && !rd_owner_dma_q && !rst;
   assign dma_rvalid = rd_valid_q &&  rd_owner_dma_q && !rst;
   assign cpu_rdata  = mem_rdata;
   assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked per cycle
// against a transaction-level reference model with its own copy of memory contents.
module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] init_val(input int i);
      return (i == 3) ? 8'hA5 : 8'((i * 37 + 11) & 255);
   endfunction

   // Physical memory driven only by the DUT's memory port.
   logic       mem_init;
   logic [7:0] phys [32];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) phys[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) phys[mem_addr] <= mem_wdata;
         else        mem_rdata <= phys[mem_addr];
      end
   end

   // Reference model: who holds the grant, who won last, and which read is due back.
   int         m_gnt;     // 0 none, 1 cpu, 2 dma
   int         m_last;    // 1 cpu, 2 dma
   int         m_rv;      // owner of the read returning this cycle, 0 none
   logic [7:0] m_rv_data;
   logic [7:0] ref_mem [32];
   bit         x_cpu, x_dma;

   int checks, errors;

   logic       smp_cpu_gnt, smp_dma_gnt, smp_cpu_rvalid, smp_dma_rvalid, smp_mem_we, smp_mem_en;
   logic [7:0] smp_cpu_rdata, smp_dma_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: entered just after a rising edge with inputs already applied.
   task automatic cycle();
      bit         xfer;
      logic       we;
      logic [4:0] a;
      logic [7:0] wd;
      int         nxt;
      #2;
      smp_cpu_gnt    = cpu_gnt;
      smp_dma_gnt    = dma_gnt;
      smp_cpu_rvalid = cpu_rvalid;
      smp_dma_rvalid = dma_rvalid;
      smp_cpu_rdata  = cpu_rdata;
      smp_dma_rdata  = dma_rdata;
      smp_mem_we     = mem_we;
      smp_mem_en     = mem_en;
      x_cpu = 1'b0;
      x_dma = 1'b0;
      nxt   = 0;
      if (rst) begin
         chk("rst_cpu_gnt", cpu_gnt, 0);
         chk("rst_dma_gnt", dma_gnt, 0);
         chk("rst_cpu_rvalid", cpu_rvalid, 0);
         chk("rst_dma_rvalid", dma_rvalid, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         m_last = 2;
         m_rv   = 0;
      end else begin
         xfer = (m_gnt == 1 && cpu_req) || (m_gnt == 2 && dma_req);
         we   = (m_gnt == 1) ? cpu_we    : dma_we;
         a    = (m_gnt == 1) ? cpu_addr  : dma_addr;
         wd   = (m_gnt == 1) ? cpu_wdata : dma_wdata;
         chk("cpu_gnt", cpu_gnt, m_gnt == 1);
         chk("dma_gnt", dma_gnt, m_gnt == 2);
         chk("one_gnt", cpu_gnt && dma_gnt, 0);
         chk("mem_en", mem_en, xfer);
         chk("mem_we", mem_we, xfer && we);
         chk("mem_addr", mem_addr, (m_gnt == 0) ? 5'd0 : a);
         chk("mem_wdata", mem_wdata, (m_gnt == 0) ? 8'd0 : wd);
         chk("cpu_rvalid", cpu_rvalid, m_rv == 1);
         chk("dma_rvalid", dma_rvalid, m_rv == 2);
         if (m_rv == 1) chk("cpu_rdata", cpu_rdata, m_rv_data);
         if (m_rv == 2) chk("dma_rdata", dma_rdata, m_rv_data);
         m_rv      = (xfer && !we) ? m_gnt : 0;
         m_rv_data = ref_mem[a];
         if (xfer && we) ref_mem[a] = wd;
         if (xfer) m_last = m_gnt;
         x_cpu = xfer && (m_gnt == 1);
         x_dma = xfer && (m_gnt == 2);
         if (cpu_req && dma_req) nxt = (m_last == 1) ? 2 : 1;
         else if (cpu_req)       nxt = 1;
         else if (dma_req)       nxt = 2;
      end
      @(posedge clk);
      #1;
      m_gnt = nxt;
   endtask

   task automatic wait_xfer(input int who, input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
         cycle();
         done = (who == 1) ? x_cpu : x_dma;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      m_gnt = 0; m_last = 2; m_rv = 0; m_rv_data = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      mem_init = 1'b1;
      @(posedge clk);
      #1;
      mem_init = 1'b0;

      // Reset then idle
      cycle();
      cycle();
      rst = 1'b0;
      repeat (5) cycle();
      chk("idle_mem_en", smp_mem_en, 0);
      chk("idle_cpu_gnt", smp_cpu_gnt, 0);

      // CPU single read of address 3
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
      wait_xfer(1, "cpu_rd_timeout");
      chk("cpu_rd_en", smp_mem_en, 1);
      cpu_req = 0;
      cycle();
      chk("cpu_rd_rvalid", smp_cpu_rvalid, 1);
      chk("cpu_rd_data", smp_cpu_rdata, 8'hA5);
      chk("cpu_rd_dma_rvalid", smp_dma_rvalid, 0);
      cycle();

      // DMA write 0x3C to 0x1F, then CPU reads it back
      dma_req = 1; dma_we = 1; dma_addr = 5'h1F; dma_wdata = 8'h3C;
      wait_xfer(2, "dma_wr_timeout");
      chk("dma_wr_we", smp_mem_we, 1);
      dma_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F;
      wait_xfer(1, "cpu_rb_timeout");
      chk("cpu_rb_we", smp_mem_we, 0);
      cpu_req = 0;
      cycle();
      chk("cpu_rb_rvalid", smp_cpu_rvalid, 1);
      chk("cpu_rb_data", smp_cpu_rdata, 8'h3C);
      cycle();

      // Contention straight out of reset: CPU wins the first tie, then strict alternation
      rst = 1;
      cycle();
      rst = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h02;
      dma_req = 1; dma_we = 0; dma_addr = 5'h04;
      cycle();
      chk("cont_idle_gnt", smp_cpu_gnt | smp_dma_gnt, 0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("cont_cpu_gnt", smp_cpu_gnt, (i % 2) == 0);
         chk("cont_dma_gnt", smp_dma_gnt, (i % 2) == 1);
      end
      cpu_req = 0;
      dma_req = 0;
      repeat (3) cycle();

      // DMA back-to-back reads of addresses 0..3
      dma_req = 1; dma_we = 0; dma_addr = 5'd0;
      wait_xfer(2, "b2b_timeout");
      for (int i = 1; i < 4; i++) begin
         dma_addr = 5'(i);
         cycle();
         chk("b2b_gnt", smp_dma_gnt, 1);
         chk("b2b_rvalid", smp_dma_rvalid, 1);
         chk("b2b_rdata", smp_dma_rdata, init_val(i - 1));
      end
      dma_req = 0;
      cycle();
      chk("b2b_last_rvalid", smp_dma_rvalid, 1);
      chk("b2b_last_rdata", smp_dma_rdata, init_val(3));
      repeat (2) cycle();

      // Reset arriving the cycle after a granted CPU read
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h05;
      wait_xfer(1, "rstrd_timeout");
      rst = 1;
      cpu_req = 0;
      cycle();
      chk("rstrd_rvalid_n1", smp_cpu_rvalid, 0);
      rst = 0;
      cycle();
      chk("rstrd_rvalid_n2", smp_cpu_rvalid, 0);
      chk("rstrd_idle", smp_cpu_gnt | smp_dma_gnt, 0);
      cpu_req = 1; dma_req = 1; dma_we = 0;
      cycle();
      cycle();
      chk("rstrd_tie_cpu", smp_cpu_gnt, 1);
      cpu_req = 0;
      dma_req = 0;
      repeat (3) cycle();

      // Random traffic with occasional resets and idle grants
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         cycle();
         if (!cpu_req || x_cpu) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 5'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
         end
         if (!dma_req || x_dma) begin
            dma_req   = ($urandom_range(0, 2) != 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = 5'($urandom_range(0, 7));
            dma_wdata = 8'($urandom);
         end
      end
      rst = 0;
      cpu_req = 0;
      dma_req = 0;
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
